lsu_axil_sram: RTL and testbench



---
 rtl/lsu_axil_sram_pkg.sv | 36 +++
 rtl/lsu_axil_sram_lat_lfsr.sv | 21 ++
 rtl/lsu_axil_sram.sv | 258 +++++++++++++++++++++++++
 tb/tb_lsu_axil_sram.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axil_sram_pkg.sv
// Shared types and constants for the LSU-facing AXI4-Lite SRAM model.
package lsu_axil_sram_pkg;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // True when addr falls inside [base, base + 4*depth)
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 5'd2) < depth);
  endfunction

  // Next feedback bit of the latency LFSR
  function automatic logic lfsr_feedback(input logic [7:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lsu_axil_sram_lat_lfsr.sv
// 8-bit Fibonacci LFSR used to jitter response latency.
module lsu_lat_lfsr
  import lsu_axil_sram_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  // Free-running shift register, reloaded with the seed on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_feedback(lfsr)};
    end
  end

endmodule

// File: rtl/lsu_axil_sram.sv
// AXI4-Lite slave SRAM with programmable/jittered latency, one read and
// one write outstanding, independent read and write state machines.
module lsu_axil_sram
  import lsu_axil_sram_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          RD_LAT      = 3,
  parameter int          WR_LAT      = 2,
  parameter int          RAND_EN     = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0] lfsr_val;
  logic [7:0] lat_extra;
  logic [7:0] rd_lat;
  logic [7:0] wr_lat;

  lsu_lat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr_val)
  );

  assign lat_extra = (RAND_EN != 0) ? {6'b000000, lfsr_val[1:0]} : 8'h00;
  assign rd_lat    = 8'(RD_LAT) + lat_extra;
  assign wr_lat    = 8'(WR_LAT) + lat_extra;

  // ---------------- read path ----------------
  rd_state_e        rd_state_r, rd_next;
  logic [7:0]       rd_cnt_r;
  logic [31:0]      rd_addr_r;
  logic [31:0]      rd_cap_addr;
  logic [IDX_W-1:0] rd_cap_idx;
  logic             rd_cap_ok;
  logic             rd_load;
  logic             rd_capture;

  // With zero latency the capture happens in the AR handshake cycle itself
  assign rd_cap_addr = (rd_state_r == R_IDLE) ? araddr : rd_addr_r;
  assign rd_cap_ok   = addr_in_range(rd_cap_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign rd_cap_idx  = IDX_W'((rd_cap_addr - BASE_ADDR) >> 5'd2);

  // Read FSM next state, arready and datapath strobes
  always_comb begin
    rd_next    = rd_state_r;
    arready    = 1'b0;
    rd_load    = 1'b0;
    rd_capture = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        arready = ~rst;
        if (arvalid && !rst) begin
          rd_load = 1'b1;
          if (rd_lat == 8'd0) begin
            rd_next    = R_RESP;
            rd_capture = 1'b1;
          end else begin
            rd_next = R_WAIT;
          end
        end else begin
          rd_next = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rd_cnt_r == 8'd1) begin
          rd_next    = R_RESP;
          rd_capture = 1'b1;
        end else begin
          rd_next = R_WAIT;
        end
      end
      R_RESP: begin
        if (rready) begin
          rd_next = R_IDLE;
        end else begin
          rd_next = R_RESP;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read state, latency counter and held response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      rd_cnt_r   <= 8'd0;
      rd_addr_r  <= 32'h0000_0000;
      rvalid     <= 1'b0;
      rdata      <= 32'h0000_0000;
      rresp      <= RESP_OKAY;
    end else begin
      rd_state_r <= rd_next;
      if (rd_load) begin
        rd_addr_r <= araddr;
        rd_cnt_r  <= rd_lat;
      end else if (rd_state_r == R_WAIT) begin
        rd_cnt_r <= rd_cnt_r - 8'd1;
      end
      if (rd_capture) begin
        rvalid <= 1'b1;
        if (rd_cap_ok) begin
          rdata <= mem[rd_cap_idx];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= 32'h0000_0000;
          rresp <= RESP_SLVERR;
        end
      end else if ((rd_state_r == R_RESP) && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- write path ----------------
  wr_state_e        wr_state_r, wr_next;
  logic [7:0]       wr_cnt_r;
  logic             aw_held_r, w_held_r;
  logic [31:0]      wr_addr_r, wdata_r;
  logic [3:0]       wstrb_r;
  logic             aw_fire, w_fire;
  logic             wr_load, wr_commit;
  logic [31:0]      wr_cap_addr, wr_cap_data;
  logic [3:0]       wr_cap_strb;
  logic             wr_cap_ok;
  logic [IDX_W-1:0] wr_cap_idx;

  // A channel accepted in the same cycle as the commit is taken straight from the bus
  assign wr_cap_addr = aw_fire ? awaddr : wr_addr_r;
  assign wr_cap_data = w_fire  ? wdata  : wdata_r;
  assign wr_cap_strb = w_fire  ? wstrb  : wstrb_r;
  assign wr_cap_ok   = addr_in_range(wr_cap_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign wr_cap_idx  = IDX_W'((wr_cap_addr - BASE_ADDR) >> 5'd2);

  // Write FSM next state, ready signals and commit strobe
  always_comb begin
    wr_next   = wr_state_r;
    awready   = 1'b0;
    wready    = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    wr_load   = 1'b0;
    wr_commit = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        awready = ~aw_held_r & ~rst;
        wready  = ~w_held_r & ~rst;
        aw_fire = awvalid & awready;
        w_fire  = wvalid & wready;
        if ((aw_held_r || aw_fire) && (w_held_r || w_fire) && !rst) begin
          wr_load = 1'b1;
          if (wr_lat == 8'd0) begin
            wr_next   = W_RESP;
            wr_commit = 1'b1;
          end else begin
            wr_next = W_WAIT;
          end
        end else begin
          wr_next = W_IDLE;
        end
      end
      W_WAIT: begin
        if ((wr_cnt_r == 8'd1) && !rst) begin
          wr_next   = W_RESP;
          wr_commit = 1'b1;
        end else begin
          wr_next = W_WAIT;
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_next = W_IDLE;
        end else begin
          wr_next = W_RESP;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Write state, channel holding registers, counter and response
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      wr_cnt_r   <= 8'd0;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      wr_addr_r  <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      wstrb_r    <= 4'b0000;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      wr_state_r <= wr_next;
      if (aw_fire) begin
        aw_held_r <= 1'b1;
        wr_addr_r <= awaddr;
      end else if ((wr_state_r == W_RESP) && bready) begin
        aw_held_r <= 1'b0;
      end
      if (w_fire) begin
        w_held_r <= 1'b1;
        wdata_r  <= wdata;
        wstrb_r  <= wstrb;
      end else if ((wr_state_r == W_RESP) && bready) begin
        w_held_r <= 1'b0;
      end
      if (wr_load) begin
        wr_cnt_r <= wr_lat;
      end else if (wr_state_r == W_WAIT) begin
        wr_cnt_r <= wr_cnt_r - 8'd1;
      end
      if (wr_commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_cap_ok ? RESP_OKAY : RESP_SLVERR;
      end else if ((wr_state_r == W_RESP) && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Byte-masked array update; same-edge reads still see the old word
  always_ff @(posedge clk) begin
    if (wr_commit && wr_cap_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_cap_strb[b]) begin
          mem[wr_cap_idx][8*b +: 8] <= wr_cap_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_axil_sram.sv
// Self-checking bench for lsu_axil_sram: directed table, corner sequences,
// and randomized traffic against a word-array reference model.
module tb_lsu_axil_sram;

  localparam int          TB_RD_LAT = 3;
  localparam int          TB_WR_LAT = 2;
  localparam logic [31:0] TB_BASE   = 32'h8000_0000;
  localparam int          TB_DEPTH  = 1024;

  logic        clk, rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl   [TB_DEPTH];
  bit          known [TB_DEPTH];

  lsu_axil_sram #(
    .DEPTH_WORDS (TB_DEPTH),
    .BASE_ADDR   (TB_BASE),
    .RD_LAT      (TB_RD_LAT),
    .WR_LAT      (TB_WR_LAT),
    .RAND_EN     (0),
    .LFSR_SEED   (8'h5A)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= TB_BASE) && (a < TB_BASE + 32'(4 * TB_DEPTH));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - TB_BASE) / 32'd4);
  endfunction

  task automatic do_read(input logic [31:0] addr, input int rdy_dly,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) chk("ar_handshake_timeout", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    araddr  = $urandom();
    lat = 1;
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rvalid) chk("rvalid_timeout", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("bp_rvalid_held", 32'(rvalid), 32'd1);
      chk("bp_rdata_stable", rdata, data);
      chk("bp_arready_low", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_after_hs", 32'(rvalid), 32'd0);
    chk("arready_after_hs", 32'(arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int lat);
    int  k;
    bit  aw_done, w_done;
    aw_done = 1'b0;
    w_done  = 1'b0;
    k = 0;
    while (!(aw_done && w_done) && k < 60) begin
      @(negedge clk);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && (k >= aw_dly);
      wvalid  = !w_done && (k >= w_dly);
      if (w_done && !aw_done) begin
        chk("w_first_wready_low", 32'(wready), 32'd0);
        chk("w_first_awready_high", 32'(awready), 32'd1);
      end
      if (aw_done && !w_done) begin
        chk("aw_first_awready_low", 32'(awready), 32'd0);
        chk("aw_first_wready_high", 32'(wready), 32'd1);
      end
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      k++;
    end
    if (!(aw_done && w_done)) chk("aw_w_handshake_timeout", 32'(k), 32'd0);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 1;
    while (!bvalid && lat < 50) begin
      chk("busy_readies_low", {30'd0, awready, wready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!bvalid) chk("bvalid_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("bp_bvalid_held", 32'(bvalid), 32'd1);
      chk("bp_bresp_stable", 32'(bresp), 32'(resp));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_after_hs", 32'(bvalid), 32'd0);
    chk("awready_after_hs", 32'(awready), 32'd1);
  endtask

  // Reference behaviour: byte-merge into the model word, SLVERR outside range
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int ix;
    if (in_rng(addr)) begin
      ix = idx_of(addr);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[ix][8*b +: 8] = data[8*b +: 8];
      end
      known[ix] = known[ix] || (strb == 4'hF);
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic write_checked(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, input int b_dly, input string name);
    logic [1:0] got, want;
    int lat;
    model_write(addr, data, strb, want);
    do_write(addr, data, strb, aw_dly, w_dly, b_dly, got, lat);
    chk({name, "_bresp"}, 32'(got), 32'(want));
    chk({name, "_wlat"}, 32'(lat), 32'(1 + TB_WR_LAT));
  endtask

  task automatic read_checked(input logic [31:0] addr, input int rdy_dly, input string name);
    logic [31:0] got;
    logic [1:0]  resp;
    int lat;
    do_read(addr, rdy_dly, got, resp, lat);
    chk({name, "_rlat"}, 32'(lat), 32'(1 + TB_RD_LAT));
    if (in_rng(addr)) begin
      chk({name, "_rresp"}, 32'(resp), 32'd0);
      if (known[idx_of(addr)]) chk({name, "_rdata"}, got, mdl[idx_of(addr)]);
    end else begin
      chk({name, "_rresp"}, 32'(resp), 32'd2);
      chk({name, "_rdata"}, got, 32'd0);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] got_d;
    logic [1:0]  got_r;
    int          got_l;
    logic [31:0] a;

    for (int i = 0; i < TB_DEPTH; i++) known[i] = 1'b0;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF,  2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,          2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,          2'b00};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD,  2'b00};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,          2'b00};
    vecs[6]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0,          2'b10};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,          2'b10};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D,  2'b00};
    vecs[9]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,          2'b00};
    vecs[10] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF,  2'b00};
    vecs[11] = '{1'b1, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0,          2'b00};
    vecs[12] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE,  2'b00};
    vecs[13] = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,          2'b10};

    rst = 1'b1; arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = 32'h0; awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp_bresp", {28'd0, rresp, bresp}, 32'd0);
    chk("rst_readies_forced_low", {29'd0, arready, awready, wready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_readies", {29'd0, arready, awready, wready}, 32'h7);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        logic [1:0] mresp;
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp);
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, got_r, got_l);
        chk($sformatf("vec%0d_bresp", i), 32'(got_r), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_wlat", i), 32'(got_l), 32'(1 + TB_WR_LAT));
      end else begin
        do_read(vecs[i].addr, 0, got_d, got_r, got_l);
        chk($sformatf("vec%0d_rdata", i), got_d, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 32'(got_r), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rlat", i), 32'(got_l), 32'(1 + TB_RD_LAT));
      end
    end

    // W accepted three cycles before AW; latency counts from the AW handshake
    write_checked(32'h8000_0040, 32'h5555_AAAA, 4'hF, 3, 0, 0, "w_before_aw");
    read_checked(32'h8000_0040, 0, "w_before_aw_rb");
    // AW before W, with B backpressure
    write_checked(32'h8000_0044, 32'h0F0F_1234, 4'hF, 0, 2, 3, "aw_before_w");
    read_checked(32'h8000_0044, 0, "aw_before_w_rb");

    // R backpressure for five cycles
    read_checked(32'h8000_0010, 5, "r_backpressure");

    // Reset pulse while the read waits for its latency to expire
    @(negedge clk);
    araddr = 32'h8000_0000;
    arvalid = 1'b1;
    chk("mid_rst_arready_idle", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_arready_forced", 32'(arready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_arready_back", 32'(arready), 32'd1);
    chk("mid_rst_rdata_cleared", rdata, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rvalid", 32'(rvalid), 32'd0);
    end
    read_checked(32'h8000_0000, 0, "after_mid_rst");

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h7FFF_FFFC - 32'($urandom_range(0, 3) * 4);
        1:       a = 32'h8000_1000 + 32'($urandom_range(0, 3) * 4);
        default: a = TB_BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        write_checked(a, $urandom(), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
      end else begin
        read_checked(a, $urandom_range(0, 3), "rnd_rd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
